hgw_sat_round_pipe: RTL and testbench

Parametrised successor to the team's combinational unsigned saturator. Right-shifts a wide sample by a per-sample amount and rounds it by mode. It then saturates the result to O_W bits, signed or unsigned, in a 2-stage valid/ready pipeline. It also keeps a saturation event counter and a sticky flag for status/CSR readback. It sits at datapath width-reduction points, e.g. after filter or accumulator outputs, before narrower storage or interfaces.

---
 rtl/hgw_sat_pkg.sv | 19 +
 rtl/hgw_sat_core.sv | 41 ++++
 rtl/hgw_sat_round_pipe.sv | 128 ++++++++++++
 tb/tb_hgw_sat_round_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hgw_sat_pkg.sv
// Shared constants and helpers for the saturating round/shift pipeline.
//   RND_*      : rounding-mode encodings carried on in_rnd
//   sat_smax() : largest two's-complement value representable in w bits
//   sat_smin() : smallest two's-complement value representable in w bits
package hgw_sat_pkg;

  localparam logic [1:0] RND_TRUNC     = 2'd0;
  localparam logic [1:0] RND_HALF_UP   = 2'd1;
  localparam logic [1:0] RND_HALF_AWAY = 2'd2;

  function automatic longint sat_smax(input int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_smin(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/hgw_sat_core.sv
// Combinational saturator: clips an (I_W+1)-bit value to O_W bits.
//   r  : value to clip (two's complement when SIGNED != 0)
//   o  : clipped value
//   hi : value was clipped to the maximum
//   lo : value was clipped to the minimum (signed only)
module hgw_sat_core
  import hgw_sat_pkg::*;
#(
  parameter int unsigned I_W    = 16,
  parameter int unsigned O_W    = 15,
  parameter int unsigned SIGNED = 0
) (
  input  logic [I_W:0]   r,
  output logic [O_W-1:0] o,
  output logic           hi,
  output logic           lo
);

  localparam logic signed [I_W:0] SMAX = (I_W + 1)'(sat_smax(O_W));
  localparam logic signed [I_W:0] SMIN = (I_W + 1)'(sat_smin(O_W));

  // Clip against the signed range, or against any set bit above the output width.
  always_comb begin
    o  = r[O_W-1:0];
    hi = 1'b0;
    lo = 1'b0;
    if (SIGNED != 0) begin
      if ($signed(r) > SMAX) begin
        o  = O_W'(SMAX);
        hi = 1'b1;
      end else if ($signed(r) < SMIN) begin
        o  = O_W'(SMIN);
        lo = 1'b1;
      end
    end else if (|r[I_W:O_W]) begin
      o  = '1;
      hi = 1'b1;
    end
  end

endmodule

// File: rtl/hgw_sat_round_pipe.sv
// Two-stage valid/ready pipeline: shift+round, then saturate to O_W bits,
// with a saturation event counter and sticky flag.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake; in_data, in_sh, in_rnd payload
//   out_valid/out_ready   : output handshake; out_data, out_sat_hi, out_sat_lo payload
//   sat_cnt, sat_sticky   : saturation status, cleared by clr
module hgw_sat_round_pipe
  import hgw_sat_pkg::*;
#(
  parameter int unsigned I_W    = 16,
  parameter int unsigned O_W    = 15,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned SH_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [I_W-1:0]   in_data,
  input  logic [SH_W-1:0]  in_sh,
  input  logic [1:0]       in_rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [O_W-1:0]   out_data,
  output logic             out_sat_hi,
  output logic             out_sat_lo,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             sat_sticky,
  input  logic             clr
);

  localparam int unsigned X_W = I_W + 1;

`ifdef RTL_SIM
  initial begin
    if (I_W <= O_W || (2 ** SH_W) > I_W) begin
      $display("ERROR: hgw_sat_round_pipe illegal parameters I_W=%0d O_W=%0d SH_W=%0d",
               I_W, O_W, SH_W);
      $finish;
    end
  end
`endif

  logic              s1_valid;
  logic [X_W-1:0]    s1_r;
  logic              s2_load;
  logic              s1_advance;
  logic [1:0]        mode;
  logic [X_W-1:0]    x_ext;
  logic [X_W-1:0]    half;
  logic [X_W-1:0]    sum;
  logic signed [X_W-1:0] sum_s;
  logic [X_W-1:0]    r_c;
  logic [O_W-1:0]    core_o;
  logic              core_hi;
  logic              core_lo;
  logic              sat_event;

  // Handshake: in_ready depends only on pipeline occupancy and out_ready.
  assign s2_load    = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_load;
  assign in_ready   = !rst && (!s1_valid || s1_advance);

  // Stage 1: one extra bit keeps the rounding add from overflowing.
  always_comb begin
    mode  = (in_rnd == 2'd3) ? RND_TRUNC : in_rnd;
    x_ext = (SIGNED != 0) ? {in_data[I_W-1], in_data} : {1'b0, in_data};
    half  = (in_sh == '0) ? '0 : (X_W'(1) << (in_sh - SH_W'(1)));
    sum   = x_ext;
    if (mode != RND_TRUNC) sum = sum + half;
    // Half-away pulls negative ties back so they round away from zero.
    if (mode == RND_HALF_AWAY && SIGNED != 0 && in_data[I_W-1]) sum = sum - X_W'(1);
    sum_s = sum;
    if (SIGNED != 0) r_c = sum_s >>> in_sh;
    else             r_c = sum >> in_sh;
  end

  hgw_sat_core #(
    .I_W    (I_W),
    .O_W    (O_W),
    .SIGNED (SIGNED)
  ) u_core (
    .r  (s1_r),
    .o  (core_o),
    .hi (core_hi),
    .lo (core_lo)
  );

  // Pipeline registers; a stage loads when empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_r       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat_hi <= 1'b0;
      out_sat_lo <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_r <= r_c;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data   <= core_o;
          out_sat_hi <= core_hi;
          out_sat_lo <= core_lo;
        end
      end
    end
  end

  assign sat_event = out_valid && out_ready && (out_sat_hi || out_sat_lo);

  // Saturation status; clr wins over a same-cycle event, counter holds at max.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sat_cnt    <= '0;
      sat_sticky <= 1'b0;
    end else if (sat_event) begin
      if (!(&sat_cnt)) sat_cnt <= sat_cnt + CNT_W'(1);
      sat_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hgw_sat_round_pipe.sv
// Scoreboard bench: two instances (unsigned 16->15, signed 16->8 with a 2-bit
// counter) share stimulus; a reference model fills per-instance queues.
module tb_hgw_sat_round_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_sh = '0;
  logic [1:0]  in_rnd = '0;

  logic        ir_u, ov_u, hi_u, lo_u, stk_u;
  logic [14:0] od_u;
  logic [15:0] cnt_u;
  logic        ir_s, ov_s, hi_s, lo_s, stk_s;
  logic [7:0]  od_s;
  logic [1:0]  cnt_s;

  always #5 clk = ~clk;

  hgw_sat_round_pipe #(.I_W(16), .O_W(15), .SIGNED(0), .SH_W(4), .CNT_W(16)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_u), .in_data(in_data),
    .in_sh(in_sh), .in_rnd(in_rnd), .out_valid(ov_u), .out_ready(out_ready),
    .out_data(od_u), .out_sat_hi(hi_u), .out_sat_lo(lo_u), .sat_cnt(cnt_u),
    .sat_sticky(stk_u), .clr(clr));

  hgw_sat_round_pipe #(.I_W(16), .O_W(8), .SIGNED(1), .SH_W(4), .CNT_W(2)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s), .in_data(in_data),
    .in_sh(in_sh), .in_rnd(in_rnd), .out_valid(ov_s), .out_ready(out_ready),
    .out_data(od_s), .out_sat_hi(hi_s), .out_sat_lo(lo_s), .sat_cnt(cnt_s),
    .sat_sticky(stk_s), .clr(clr));

  logic        ov [2];
  logic        ir [2];
  logic        hi [2];
  logic        lo [2];
  logic        stk [2];
  logic [15:0] od [2];
  logic [15:0] cnt [2];

  assign ov[0] = ov_u;  assign ov[1] = ov_s;
  assign ir[0] = ir_u;  assign ir[1] = ir_s;
  assign hi[0] = hi_u;  assign hi[1] = hi_s;
  assign lo[0] = lo_u;  assign lo[1] = lo_s;
  assign stk[0] = stk_u; assign stk[1] = stk_s;
  assign od[0] = 16'(od_u); assign od[1] = 16'(od_s);
  assign cnt[0] = cnt_u; assign cnt[1] = 16'(cnt_s);

  typedef struct {
    logic [15:0] d;
    logic        hi;
    logic        lo;
    int          acc;
    bit          strict;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   e;
  exp_t   ne;
  int     cyc = 0;
  int     nchk = 0;
  int     npass = 0;
  longint mcnt [2] = '{0, 0};
  bit     mstk [2] = '{0, 0};
  bit     seen [2] = '{0, 0};
  bit     popsat [2];
  bit     prev_rst = 1'b0;
  bit     strict_mode = 1'b0;

  task automatic chk(input string n, input int p, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) $display("FAIL %s[dut%0d]: got 0x%0h, want 0x%0h", n, p, act, exp);
    else npass++;
  endtask

  // Arithmetic reference: floor(rounded value / 2^sh), then clip to the output range.
  function automatic exp_t model(input int p, input logic [15:0] x, input logic [3:0] sh,
                                 input logic [1:0] rnd);
    exp_t   r;
    longint v, h, mx, mn;
    bit     neg;
    int     w;
    w   = (p == 0) ? 15 : 8;
    v   = (p == 1) ? longint'($signed(x)) : longint'(x);
    neg = (v < 0);
    h   = (sh == 0) ? 0 : (longint'(1) << (sh - 1));
    if (rnd == 2'd1 || rnd == 2'd2) v = v + h;
    if (rnd == 2'd2 && neg) v = v - 1;
    v = v >>> sh;
    if (p == 1) begin
      mx = (longint'(1) << (w - 1)) - 1;
      mn = -(longint'(1) << (w - 1));
    end else begin
      mx = (longint'(1) << w) - 1;
      mn = 0;
    end
    r.hi = 1'b0;
    r.lo = 1'b0;
    if (v > mx) begin r.hi = 1'b1; v = mx; end
    else if (v < mn) begin r.lo = 1'b1; v = mn; end
    r.d      = 16'(v & ((longint'(1) << w) - 1));
    r.acc    = 0;
    r.strict = 1'b0;
    return r;
  endfunction

  // Monitor: status checks, output compare against queue front, input capture.
  always @(negedge clk) begin
    cyc++;
    for (int p = 0; p < 2; p++) begin
      chk("sat_cnt", p, 64'(cnt[p]), 64'(mcnt[p]));
      chk("sat_sticky", p, 64'(stk[p]), 64'(mstk[p]));
      if (prev_rst) begin
        chk("rst_out_valid", p, 64'(ov[p]), 64'd0);
        chk("rst_out_data", p, 64'(od[p]), 64'd0);
        chk("rst_sat_hi", p, 64'(hi[p]), 64'd0);
        chk("rst_sat_lo", p, 64'(lo[p]), 64'd0);
      end
      if (rst) chk("in_ready_in_rst", p, 64'(ir[p]), 64'd0);
      else if (prev_rst) chk("in_ready_after_rst", p, 64'(ir[p]), 64'd1);
    end
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int p = 0; p < 2; p++) begin
        mcnt[p] = 0; mstk[p] = 1'b0; seen[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        popsat[p] = 1'b0;
        if (ov[p]) begin
          if ((p == 0 ? q0.size() : q1.size()) == 0) begin
            chk("unexpected_out", p, 64'(ov[p]), 64'd0);
          end else begin
            e = (p == 0) ? q0[0] : q1[0];
            if (!seen[p]) begin
              seen[p] = 1'b1;
              if (e.strict) chk("latency", p, 64'(cyc - e.acc), 64'd2);
              else chk("latency_min", p, 64'(cyc - e.acc >= 2), 64'd1);
            end
            chk("out_data", p, 64'(od[p]), 64'(e.d));
            chk("out_sat_hi", p, 64'(hi[p]), 64'(e.hi));
            chk("out_sat_lo", p, 64'(lo[p]), 64'(e.lo));
            if (out_ready) begin
              if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
              seen[p]   = 1'b0;
              popsat[p] = e.hi || e.lo;
            end
          end
        end
        if (clr) begin
          mcnt[p] = 0; mstk[p] = 1'b0;
        end else if (popsat[p]) begin
          if (mcnt[p] < (p == 0 ? 65535 : 3)) mcnt[p] = mcnt[p] + 1;
          mstk[p] = 1'b1;
        end
      end
      if (in_valid && ir[0]) begin
        for (int p = 0; p < 2; p++) begin
          ne        = model(p, in_data, in_sh, in_rnd);
          ne.acc    = cyc;
          ne.strict = strict_mode;
          if (p == 0) q0.push_back(ne); else q1.push_back(ne);
        end
      end
    end
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [3:0] sh, input logic [1:0] rnd);
    bit a;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    in_sh    = sh;
    in_rnd   = rnd;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      a = ir[0];
      tick();
      done = a;
    end
    if (!done) chk("send_timeout", 0, 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (q0.size() == 0 && q1.size() == 0) done = 1'b1;
      else tick();
    end
    if (!done) chk("drain_timeout", 0, 64'd0, 64'd1);
  endtask

  initial begin
    int  acc;
    bit  hit;
    logic [7:0] b;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Directed vectors at full throughput with exact latency.
    strict_mode = 1'b1;
    out_ready   = 1'b1;
    send(16'h8000, 4'd0, 2'd0);
    send(16'h1234, 4'd0, 2'd0);
    send(16'h0003, 4'd1, 2'd1);
    send(16'h0003, 4'd1, 2'd0);
    send(16'hFFFF, 4'd1, 2'd1);
    send(16'h0100, 4'd0, 2'd0);
    send(16'hFFFD, 4'd1, 2'd2);
    send(16'hFFFF, 4'd1, 2'd2);
    send(16'h7FFF, 4'd4, 2'd3);
    send(16'h8001, 4'd15, 2'd2);
    drain();
    strict_mode = 1'b0;

    // Backpressure: only two samples fit while the output is stalled.
    out_ready = 1'b0;
    acc       = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 16'($urandom);
      in_sh   = 4'($urandom);
      in_rnd  = 2'($urandom);
      @(negedge clk);
      if (ir[0]) acc++;
      if (i == 2) chk("bp_in_ready", 0, 64'(ir[0]), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 0, 64'(acc), 64'd2);
    out_ready = 1'b1;
    drain();

    // Counter saturation on the 2-bit counter, then clr against a 6th event.
    for (int i = 0; i < 5; i++) send(16'h7FFF, 4'd0, 2'd0);
    drain();
    tick();
    chk("cnt_saturated", 1, 64'(cnt[1]), 64'd3);
    chk("sticky_set", 1, 64'(stk[1]), 64'd1);
    send(16'h7FFF, 4'd0, 2'd0);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (ov[1]) begin
        hit = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
      end else begin
        tick();
      end
    end
    if (!hit) chk("clr_wait_timeout", 1, 64'd0, 64'd1);
    tick();
    chk("cnt_after_clr", 1, 64'(cnt[1]), 64'd0);
    chk("sticky_after_clr", 1, 64'(stk[1]), 64'd0);

    // Randomised traffic with random backpressure and occasional clr.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        in_data = 16'($urandom);
      end else begin
        b       = 8'($urandom);
        in_data = {{8{b[7]}}, b};
      end
      in_sh     = 4'($urandom);
      in_rnd    = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with both stages full, then one sample with exact latency.
    out_ready = 1'b0;
    send(16'h4321, 4'd2, 2'd1);
    send(16'h8765, 4'd3, 2'd2);
    chk("pre_rst_full", 0, 64'(ov[0]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    strict_mode = 1'b1;
    out_ready   = 1'b1;
    send(16'hF00D, 4'd3, 2'd1);
    drain();
    repeat (3) tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
